// File: rtl/vblank_update_arbiter.sv
// Vblank update arbiter: round-robin access to the shared game-state write port, granted
// only inside a fixed window that opens on every vsync rise.
module vblank_update_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned WINDOW_CYCLES = 59000,
  parameter int unsigned MAX_HOLD      = 4096,
  parameter int unsigned MIN_SLOT      = 64,
  localparam int unsigned IdW          = $clog2(N_REQ),
  localparam int unsigned WinW         = $clog2(WINDOW_CYCLES + 1),
  localparam int unsigned HoldW        = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic [N_REQ-1:0] req,
  input  logic             clr_err,
  output logic [N_REQ-1:0] grant,
  output logic [IdW-1:0]   gnt_id,
  output logic             win_active,
  output logic             frame_tick,
  output logic [15:0]      frame_cnt,
  output logic             err_hold,
  output logic             err_overlap
);

  typedef enum logic [1:0] {StIdle, StArb, StGrant} state_e;

  state_e            state;
  logic              vsync_d;
  logic [WinW-1:0]   win_cnt;
  logic [HoldW-1:0]  hold_cnt;
  logic [IdW-1:0]    rr;

  logic              vs_rise;
  logic              hold_lim;
  logic              force_rel;
  logic              pick_vld;
  logic [IdW-1:0]    pick;
  logic [IdW-1:0]    cand;

  assign vs_rise   = vsync & ~vsync_d;
  assign hold_lim  = (32'(hold_cnt) == MAX_HOLD - 1);
  // Forced (error) release only when the owner still wants the port.
  assign force_rel = (state == StGrant) & req[gnt_id] & (hold_lim | (win_cnt == '0));

  // Round-robin scan starting just after the most recent grantee.
  always_comb begin
    pick     = rr;
    pick_vld = 1'b0;
    cand     = rr;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdW'((32'(rr) + k) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      vsync_d     <= 1'b0;
      win_cnt     <= '0;
      hold_cnt    <= '0;
      rr          <= IdW'(N_REQ - 1);
      grant       <= '0;
      gnt_id      <= '0;
      win_active  <= 1'b0;
      frame_tick  <= 1'b0;
      frame_cnt   <= '0;
      err_hold    <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      frame_tick  <= vs_rise;
      err_hold    <= (err_hold & ~clr_err) | (force_rel & ~vs_rise);
      err_overlap <= (err_overlap & ~clr_err) | (vs_rise & (state != StIdle));

      if (state != StIdle && win_cnt != '0) begin
        win_cnt <= win_cnt - WinW'(1);
      end

      if (vs_rise) begin
        // A new frame always restarts the window, even if the old one is still open.
        frame_cnt  <= frame_cnt + 16'd1;
        win_cnt    <= WinW'(WINDOW_CYCLES);
        win_active <= 1'b1;
        grant      <= '0;
        state      <= StArb;
      end else begin
        unique case (state)
          StIdle: begin
            grant <= '0;
          end
          StArb: begin
            if (32'(win_cnt) < MIN_SLOT) begin
              state      <= StIdle;
              win_active <= 1'b0;
            end else if (pick_vld) begin
              grant    <= N_REQ'(1) << pick;
              gnt_id   <= pick;
              rr       <= pick;
              hold_cnt <= '0;
              state    <= StGrant;
            end
          end
          StGrant: begin
            hold_cnt <= hold_cnt + HoldW'(1);
            if (!req[gnt_id] || hold_lim || win_cnt == '0) begin
              grant <= '0;
              state <= StArb;
            end
          end
          default: begin
            grant      <= '0;
            win_active <= 1'b0;
            state      <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Bench for vblank_update_arbiter: random requesters and vsync against a frame-level
// reference model; expected snapshots and grant events are checked by a separate monitor.
module tb_vblank_update_arbiter;

  localparam int N    = 4;
  localparam int WIN  = 100;
  localparam int HOLD = 20;
  localparam int MINS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b0;
  logic [3:0]  req = '0;
  logic        clr_err = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  gnt_id;
  logic        win_active;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        err_hold;
  logic        err_overlap;

  vblank_update_arbiter #(
    .N_REQ(N), .WINDOW_CYCLES(WIN), .MAX_HOLD(HOLD), .MIN_SLOT(MINS)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .req(req), .clr_err(clr_err),
    .grant(grant), .gnt_id(gnt_id), .win_active(win_active), .frame_tick(frame_tick),
    .frame_cnt(frame_cnt), .err_hold(err_hold), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  grant;
    logic [1:0]  id;
    logic        win;
    logic        tick;
    logic [15:0] fcnt;
    logic        eh;
    logic        eo;
  } snap_t;

  snap_t sq[$];
  int    gq[$];

  int        m_cyc = 0;
  int        m_load = 0;
  bit        m_open, m_vsp, m_tick, m_eh, m_eo;
  int        m_owner, m_age, m_last, m_rr;
  bit [15:0] m_frames;

  function automatic snap_t m_snap();
    snap_t s;
    s.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    s.id    = 2'(m_last);
    s.win   = m_open;
    s.tick  = m_tick;
    s.fcnt  = m_frames;
    s.eh    = m_eh;
    s.eo    = m_eo;
    return s;
  endfunction

  task automatic m_reset();
    m_open = 0; m_vsp = 0; m_tick = 0; m_eh = 0; m_eo = 0;
    m_owner = -1; m_age = 0; m_last = 0; m_rr = N - 1; m_frames = 0;
  endtask

  task automatic m_step();
    bit rise, sh, so, found;
    int left, id;
    m_cyc++;
    rise  = vsync && !m_vsp;
    m_vsp = vsync;
    // Window cycles remaining, from the absolute cycle at which the window was loaded.
    left = m_open ? WIN - (m_cyc - m_load - 1) : 0;
    if (left < 0) left = 0;
    sh = 0; so = 0;
    m_tick = rise;
    if (rise) begin
      if (m_open) so = 1;
      m_frames++;
      m_open  = 1;
      m_owner = -1;
      m_load  = m_cyc;
    end else if (m_open) begin
      if (m_owner < 0) begin
        if (left < MINS) begin
          m_open = 0;
        end else begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            id = (m_rr + k) % N;
            if (!found && req[id]) begin
              found = 1; m_owner = id; m_age = 0; m_last = id; m_rr = id;
              gq.push_back(id);
            end
          end
        end
      end else begin
        if (!req[m_owner]) m_owner = -1;
        else if (m_age == HOLD - 1 || left == 0) begin
          m_owner = -1; sh = 1;
        end else m_age++;
      end
    end
    m_eh = (m_eh && !clr_err) || sh;
    m_eo = (m_eo && !clr_err) || so;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
        sq.delete();
        gq.delete();
      end else begin
        m_step();
      end
      sq.push_back(m_snap());
    end
  end

  // ---------------- monitor ----------------
  snap_t      exp_s;
  logic [3:0] prev_g = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        exp_s = sq.pop_front();
        chk("grant", grant, exp_s.grant);
        chk("gnt_id", gnt_id, exp_s.id);
        chk("win_active", win_active, exp_s.win);
        chk("frame_tick", frame_tick, exp_s.tick);
        chk("frame_cnt", frame_cnt, exp_s.fcnt);
        chk("err_hold", err_hold, exp_s.eh);
        chk("err_overlap", err_overlap, exp_s.eo);
        if (grant != 4'b0 && prev_g == 4'b0) begin
          if (gq.size() == 0) chk("grant_unexpected", grant, 0);
          else chk("grant_evt_id", gnt_id, gq.pop_front());
        end
        prev_g = grant;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit en[N];
  int len[N];
  int served[N];
  int rate = 0, len_lo = 1, len_hi = 1, vs_left = 0, clr_rate = 0;

  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (grant[i]) served[i]++;
        if (served[i] >= len[i]) begin
          req[i] = 1'b0;
          served[i] = 0;
        end
      end else if (en[i] && int'($urandom_range(0, 99)) < rate) begin
        req[i]    = 1'b1;
        len[i]    = int'($urandom_range(len_lo, len_hi));
        served[i] = 0;
      end
    end
    if (vs_left > 0) vs_left--;
    vsync   = (vs_left > 0);
    clr_err = (clr_rate > 0) && (int'($urandom_range(0, 99)) < clr_rate);
  endtask

  task automatic vs_fire();
    vsync   = 1'b1;
    vs_left = 3;
  endtask

  task automatic agents(input bit on, input int r, input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      en[i] = on; served[i] = 0; len[i] = hi;
    end
    rate = r; len_lo = lo; len_hi = hi;
  endtask

  int rr_seen[$];
  int run, n, f0;
  logic [3:0] dprev;

  initial begin
    agents(0, 0, 1000, 1000);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Requests with no vsync edge: window must stay closed.
    req = 4'b1111;
    repeat (30) step();
    chk("idle_grant", grant, 0);
    chk("idle_win", win_active, 0);
    chk("idle_fcnt", frame_cnt, 0);

    // Round-robin: every requester holds for 5 granted cycles, then re-requests.
    agents(1, 100, 5, 5);
    req = 4'b1111;
    vs_fire();
    dprev = '0;
    for (n = 0; n < 80 && rr_seen.size() < 5; n++) begin
      step();
      if (grant != 4'b0 && dprev == 4'b0) rr_seen.push_back(int'(gnt_id));
      dprev = grant;
    end
    chk("rr_count", rr_seen.size(), 5);
    for (int i = 0; i < 5 && i < rr_seen.size(); i++) chk("rr_order", rr_seen[i], i % N);
    chk("rr_fcnt", frame_cnt, 1);
    agents(0, 0, 1000, 1000);
    req = '0;
    for (n = 0; n < 150 && win_active; n++) step();
    chk("rr_closed", win_active, 0);

    // Hold limit: requester 2 alone, never lets go.
    clr_err = 1'b1;
    step();
    chk("hold_clr", err_hold, 0);
    en[2] = 1; rate = 100; len_lo = 1000; len_hi = 1000;
    req = 4'b0100;
    vs_fire();
    for (n = 0; n < 10 && grant == 4'b0; n++) step();
    chk("hold_start", grant, 4'b0100);
    run = 0;
    while (grant == 4'b0100 && run < 50) begin
      run++;
      step();
    end
    chk("hold_len", run, HOLD);
    chk("hold_gap", grant, 0);
    chk("hold_err", err_hold, 1);
    step();
    chk("hold_regrant", grant, 4'b0100);

    // Window end with the same requester still pending.
    for (n = 0; n < 150 && win_active; n++) step();
    chk("win_closed", win_active, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("closed_grant", grant, 0);
    end
    en[2] = 0;
    req = '0;

    // Overlap: second vsync rise 50 cycles into a window while requester 1 is granted.
    clr_err = 1'b1;
    step();
    en[1] = 1; rate = 100;
    req = 4'b0010;
    f0 = int'(frame_cnt);
    vs_fire();
    repeat (50) step();
    chk("ovl_pre", grant, 4'b0010);
    vs_fire();
    step();
    chk("ovl_drop", grant, 0);
    chk("ovl_err", err_overlap, 1);
    chk("ovl_fcnt", frame_cnt, 16'(f0 + 2));
    chk("ovl_win", win_active, 1);
    en[1] = 0;
    req = '0;
    repeat (2) step();
    clr_err = 1'b1;
    step();
    chk("clr_hold", err_hold, 0);
    chk("clr_ovl", err_overlap, 0);

    // Asynchronous reset in the middle of a grant.
    en[1] = 1;
    req = 4'b0010;
    for (n = 0; n < 30 && grant != 4'b0010; n++) step();
    chk("arst_pre", grant, 4'b0010);
    #1 rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_win", win_active, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_grant", grant, 0);
    end
    vs_fire();
    for (n = 0; n < 10 && grant == 4'b0; n++) step();
    chk("post_rst_regrant", grant, 4'b0010);
    chk("post_rst_fcnt", frame_cnt, 1);

    // Random traffic with random frame spacing (some overlapping) and error clears.
    agents(1, 8, 1, 30);
    clr_rate = 3;
    for (int f = 0; f < 15; f++) begin
      vs_fire();
      repeat (int'($urandom_range(60, 160))) step();
    end
    agents(0, 0, 1000, 1000);
    clr_rate = 0;
    req = '0;
    repeat (5) step();
    chk("gq_drain", gq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
